// File: rtl/imem_bank.sv
// Instruction memory bank: power-on clear, streamed program load, registered fetch
// with misalignment/range faults. Optional per-word even parity via IMEM_BANK_PARITY_EN.
module imem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] Address,
  input  logic              ReadEn,
  output logic [DATA_W-1:0] ReadData,
  output logic              ReadValid,
  output logic [1:0]        Fault,
  input  logic              LoadStart,
  input  logic              LoadValid,
  input  logic [DATA_W-1:0] LoadData,
  input  logic              LoadLast,
  output logic              LoadReady,
  output logic              LoadDone,
  output logic              Busy,
  output logic              ParityErr,
  output logic [1:0]        fsm_state
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_BANK_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  // Load handshake: a word transfers on any rising edge where LoadValid and
  // LoadReady are both high; LoadReady is high for the whole LOAD state and
  // does not depend on LoadValid.
  state_t state, state_next;

  logic [IDX_W-1:0]  idx;
  logic              last_idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [MEM_W-1:0]  mem_word;
  logic              idx_inc, idx_zero, fetch, done_set;
  logic              misaligned, out_range;
  logic [IDX_W-1:0]  word_addr;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  ram_q;
  logic              valid_q, zero_q, done_q;
  logic [1:0]        fault_q;

  assign last_idx   = (idx == IDX_W'(DEPTH - 1));
  assign misaligned = |Address[1:0];
  assign out_range  = |Address[ADDR_W-1:IDX_W+2];
  assign word_addr  = Address[IDX_W+1:2];

`ifdef IMEM_BANK_PARITY_EN
  assign mem_word = {^mem_wdata, mem_wdata};
`else
  assign mem_word = mem_wdata;
`endif

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    idx_inc    = 1'b0;
    idx_zero   = 1'b0;
    fetch      = 1'b0;
    done_set   = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we  = 1'b1;
        idx_inc = 1'b1;
        if (last_idx) state_next = S_IDLE;
      end
      S_IDLE: begin
        // A simultaneous fetch is dropped in favour of the load.
        if (LoadStart) begin
          state_next = S_LOAD;
          idx_zero   = 1'b1;
        end else if (ReadEn) begin
          fetch = 1'b1;
        end
      end
      S_LOAD: begin
        if (LoadValid) begin
          mem_we    = 1'b1;
          mem_wdata = LoadData;
          idx_inc   = 1'b1;
          if (LoadLast || last_idx) begin
            state_next = S_IDLE;
            done_set   = 1'b1;
          end
        end
      end
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_CLEAR;
      idx     <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
      fault_q <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      valid_q <= fetch;
      done_q  <= done_set;
      if (idx_zero)     idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (fetch) begin
        fault_q <= {out_range, misaligned};
        zero_q  <= out_range | misaligned;
      end
    end
  end

  // Array and read register carry no reset so the storage maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx] <= mem_word;
    if (fetch)  ram_q <= mem[word_addr];
  end

  assign ReadData  = zero_q ? '0 : ram_q[DATA_W-1:0];
  assign ReadValid = valid_q;
  assign Fault     = fault_q;
  assign LoadReady = (state == S_LOAD);
  assign LoadDone  = done_q;
  assign Busy      = (state != S_IDLE);
  assign fsm_state = state;

`ifdef IMEM_BANK_PARITY_EN
  assign ParityErr = valid_q & ~zero_q & (^ram_q);
`else
  assign ParityErr = 1'b0;
`endif

endmodule

// File: doc/imem_bank.md
IMEM_BANK -- requirements
Module: imem_bank

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 64, number of words; power of two, 4..4096.
REQ-003 Parameter ADDR_W, default 32, byte-address width.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 Address  input  ADDR_W  byte address of the fetch.
REQ-007 ReadEn  input  1  fetch request, sampled each cycle.
REQ-008 ReadData  output  DATA_W  registered fetched word.
REQ-009 ReadValid  output  1  ReadData/Fault are valid this cycle.
REQ-010 Fault  output  2  bit0 misaligned, bit1 out of range; qualified by ReadValid.
REQ-011 LoadStart  input  1  begin program load at word 0.
REQ-012 LoadValid  input  1  LoadData carries a word.
REQ-013 LoadData  input  DATA_W  word to store.
REQ-014 LoadLast  input  1  marks final word of the load, qualified by LoadValid.
REQ-015 LoadReady  output  1  bank accepts a load word this cycle.
REQ-016 LoadDone  output  1  one-cycle pulse when a load completes.
REQ-017 Busy  output  1  high in CLEAR and LOAD states.
REQ-018 ParityErr  output  1  parity mismatch on a fetch, qualified by ReadValid.

Function
REQ-019 FSM states: CLEAR, IDLE, LOAD; one-hot or binary is an implementation choice.
REQ-020 CLEAR: write zero to one word per cycle, index 0..DEPTH-1, then go to IDLE; takes exactly DEPTH cycles.
REQ-021 IDLE: LoadStart=1 -> LOAD with write index 0; otherwise stay.
REQ-022 LOAD: LoadReady=1; on LoadValid&LoadReady write LoadData at the index and increment it.
REQ-023 LOAD exit: on an accepted word with LoadLast=1, or on the word at index DEPTH-1 -> IDLE, with LoadDone=1 in the next cycle only.
REQ-024 LoadStart in CLEAR or LOAD is ignored; unwritten words keep their prior contents.
REQ-025 Fetch: in IDLE, ReadEn=1 -> ReadValid=1 exactly one cycle later, with ReadData = word[Address >> 2].
REQ-026 Address[1:0] != 0 -> Fault[0]=1, ReadData=0.
REQ-027 Address >= 4*DEPTH -> Fault[1]=1, ReadData=0; both fault bits may be set together.
REQ-028 ReadEn in CLEAR or LOAD -> request dropped, ReadValid=0 next cycle.
REQ-029 ReadEn and LoadStart both high in IDLE -> the load wins and the read is dropped.
REQ-030 Without a fetch, ReadValid=0 and ReadData holds its last value.
REQ-031 Storage is a synchronous RAM with no reset on the array, so it infers block RAM.

Reset
REQ-032 RESET=1 -> state CLEAR, clear index 0, ReadData=0, ReadValid=0, Fault=0, LoadReady=0, LoadDone=0, ParityErr=0, Busy=1.
REQ-033 RESET during LOAD abandons the load; no LoadDone pulse; the full CLEAR sequence reruns.
REQ-034 After RESET deasserts, the bank is Busy for DEPTH cycles before the first fetch is serviced.

Configuration
REQ-035 Macro IMEM_BANK_PARITY_EN defined -> each word stores an extra even-parity bit, written on CLEAR/LOAD and checked on fetch; a mismatch sets ParityErr=1 alongside ReadValid, and ReadData is still returned.
REQ-036 Macro undefined -> no parity storage and ParityErr tied to 0.

Verification
REQ-037 Reset, wait DEPTH=64 cycles, fetch Address=0x0C -> ReadValid next cycle, ReadData=0, Fault=0, Busy low from cycle 64.
REQ-038 LoadStart, then 4 words 0x00000013, 0x00100093, 0x00200113, 0x00308193 with LoadLast on the 4th -> LoadDone pulse; fetch 0x8 -> 0x00200113.
REQ-039 Fetch 0x6 -> Fault=01, ReadData=0; fetch 0x100 with DEPTH=64 -> Fault=10; fetch 0x102 -> Fault=11.
REQ-040 ReadEn with LoadStart in the same IDLE cycle -> ReadValid=0 next cycle, LoadReady=1; a ReadEn during LOAD is also dropped.
REQ-041 Assert RESET after the 2nd load word -> no LoadDone; after CLEAR, fetches 0x0 and 0x4 both return 0.
REQ-042 With IMEM_BANK_PARITY_EN, force-flip one stored bit of word 1, fetch 0x4 -> ParityErr=1; without the macro, ParityErr stays 0 throughout.
